// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the Memory Access stage (master) and data memory (slave).
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// RISC-V Memory Access stage: req/ack data bus with timeout, store alignment, load extension, MEM/WB register.
// Optional MISALIGN_TRAP_EN: misaligned h/w accesses skip the bus and pulse MisalignW instead.
module mem_access_stage #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    mem_access_stage_if.master        dmem,
    input  logic [31:0]               ALUResultM,
    input  logic [31:0]               WriteDataM,
    input  logic [4:0]                RdM,
    input  logic [31:0]               PCPlus4M,
    input  logic                      RegWriteM,
    input  logic [1:0]                ResultSrcM,
    input  logic                      MemReadM,
    input  logic                      MemWriteM,
    input  logic [2:0]                Funct3M,
    output logic                      StallM,
    output logic [31:0]               ALUResultW,
    output logic [31:0]               ReadDataW,
    output logic [31:0]               PCPlus4W,
    output logic [4:0]                RdW,
    output logic [1:0]                ResultSrcW,
    output logic                      RegWriteW,
    output logic                      BusErrW
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                      MisalignW
`endif
);

    typedef enum logic {IDLE, BUS} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [31:0] aluResultW_q, aluResultW_d, readDataW_q, readDataW_d, pcPlus4W_q, pcPlus4W_d;
    logic [4:0]  rdW_q, rdW_d;
    logic [1:0]  resultSrcW_q, resultSrcW_d;
    logic        regWriteW_q, regWriteW_d, busErrW_q, busErrW_d;

    logic        memOp, isByte, isHalf, misaligned;
    logic [3:0]  storeBe;
    logic [31:0] storeWdata, loadData;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    assign memOp  = MemReadM | MemWriteM;
    assign isByte = (Funct3M[1:0] == 2'b00);
    assign isHalf = (Funct3M[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
    logic misalignW_q, misalignW_d;
    assign misaligned = memOp && ((isHalf && ALUResultM[0]) ||
                                  (!isByte && !isHalf && (ALUResultM[1:0] != 2'b00)));
    assign MisalignW  = misalignW_q;
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        storeBe    = 4'b1111;
        storeWdata = WriteDataM;
        if (isByte) begin
            storeBe    = 4'b0001 << ALUResultM[1:0];
            storeWdata = {4{WriteDataM[7:0]}};
        end else if (isHalf) begin
            storeBe    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            storeWdata = {2{WriteDataM[15:0]}};
        end
    end

    // Extension uses the size/offset latched at issue, not the live M inputs.
    always_comb begin
        loadByte = dmem.dmem_rdata[{off_q, 3'b000} +: 8];
        loadHalf = dmem.dmem_rdata[{off_q[1], 4'b0000} +: 16];
        loadData = dmem.dmem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            loadData = funct3_q[2] ? {24'b0, loadByte} : {{24{loadByte[7]}}, loadByte};
        end else if (funct3_q[1:0] == 2'b01) begin
            loadData = funct3_q[2] ? {16'b0, loadHalf} : {{16{loadHalf[15]}}, loadHalf};
        end
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        StallM       = 1'b0;
        aluResultW_d = 32'b0;
        readDataW_d  = 32'b0;
        pcPlus4W_d   = 32'b0;
        rdW_d        = 5'b0;
        resultSrcW_d = 2'b0;
        regWriteW_d  = 1'b0;
        busErrW_d    = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misalignW_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (memOp && !misaligned) begin
                    StallM   = 1'b1;
                    state_d  = BUS;
                    req_d    = 1'b1;
                    we_d     = MemWriteM;
                    addr_d   = {ALUResultM[31:2], 2'b00};
                    be_d     = MemWriteM ? storeBe : 4'b1111;
                    wdata_d  = storeWdata;
                    funct3_d = Funct3M;
                    off_d    = ALUResultM[1:0];
                    cnt_d    = 8'd0;
                end else begin
                    aluResultW_d = ALUResultM;
                    pcPlus4W_d   = PCPlus4M;
                    rdW_d        = RdM;
                    resultSrcW_d = ResultSrcM;
                    regWriteW_d  = RegWriteM && !misaligned;
`ifdef MISALIGN_TRAP_EN
                    misalignW_d  = misaligned;
`endif
                end
            end
            BUS: begin
                if (dmem.dmem_ack || cnt_q == LAST_WAIT) begin
                    state_d      = IDLE;
                    req_d        = 1'b0;
                    we_d         = 1'b0;
                    cnt_d        = 8'd0;
                    aluResultW_d = ALUResultM;
                    pcPlus4W_d   = PCPlus4M;
                    rdW_d        = RdM;
                    resultSrcW_d = ResultSrcM;
                    if (dmem.dmem_ack) begin
                        regWriteW_d = RegWriteM;
                        readDataW_d = we_q ? 32'b0 : loadData;
                    end else begin
                        busErrW_d   = 1'b1;
                    end
                end else begin
                    StallM = 1'b1;
                    cnt_d  = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'b0;
            wdata_q      <= 32'b0;
            be_q         <= 4'b0;
            funct3_q     <= 3'b0;
            off_q        <= 2'b0;
            cnt_q        <= 8'd0;
            aluResultW_q <= 32'b0;
            readDataW_q  <= 32'b0;
            pcPlus4W_q   <= 32'b0;
            rdW_q        <= 5'b0;
            resultSrcW_q <= 2'b0;
            regWriteW_q  <= 1'b0;
            busErrW_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalignW_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            aluResultW_q <= aluResultW_d;
            readDataW_q  <= readDataW_d;
            pcPlus4W_q   <= pcPlus4W_d;
            rdW_q        <= rdW_d;
            resultSrcW_q <= resultSrcW_d;
            regWriteW_q  <= regWriteW_d;
            busErrW_q    <= busErrW_d;
`ifdef MISALIGN_TRAP_EN
            misalignW_q  <= misalignW_d;
`endif
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    assign ALUResultW = aluResultW_q;
    assign ReadDataW  = readDataW_q;
    assign PCPlus4W   = pcPlus4W_q;
    assign RdW        = rdW_q;
    assign ResultSrcW = resultSrcW_q;
    assign RegWriteW  = regWriteW_q;
    assign BusErrW    = busErrW_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- RISC-V pipeline Memory Access stage. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs (address/ALU result, store data, Rd, PC+4), plus the M-stage control bits.
- Drives a req/ack data-memory bus and stalls the pipeline while an access is outstanding.
- Aligns store data and byte enables, and extends load data.
- Contains the MEM/WB pipeline register feeding Writeback.

Parameters:
WAIT_LIMIT, 255, max cycles to wait for dmem_ack before aborting (1..255; 8-bit counter)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
ALUResultM  in  32  ALU result / memory byte address
WriteDataM  in  32  store data (rs2)
RdM  in  5  destination register
PCPlus4M  in  32  PC+4
RegWriteM  in  1  register write enable
ResultSrcM  in  2  writeback mux select (passed through)
MemReadM  in  1  load
MemWriteM  in  1  store (MemReadM&MemWriteM never both 1)
Funct3M  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
StallM  out  1  hold EX/MEM and upstream stages
dmem_req  out  1  bus request
dmem_we  out  1  1=write
dmem_addr  out  32  word address ({addr[31:2],2'b00})
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ack  in  1  access complete; rdata valid same cycle
dmem_rdata  in  32  read word
ALUResultW, ReadDataW, PCPlus4W  out  32  MEM/WB register
RdW  out  5;  ResultSrcW  out  2;  RegWriteW  out  1
BusErrW  out  1  timed-out access reached WB

Behaviour:
- Reset (async, reset_n=0): state IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0; all W outputs 0; wait counter 0. An in-flight request is dropped immediately; a late ack is ignored.
- FSM has two states, IDLE and BUS.
- IDLE, no memory op:
  - StallM=0.
  - At the next edge the W register loads the M inputs; ReadDataW=0 and BusErrW=0.
  - Latency is 1 cycle.
- IDLE, MemReadM|MemWriteM:
  - StallM=1 combinationally.
  - At the edge: register dmem_addr, dmem_we=MemWriteM, dmem_be, dmem_wdata, and the latched Funct3/addr[1:0]; set dmem_req=1; go to BUS.
  - W register loads a bubble (RegWriteW=0, RdW=0, BusErrW=0).
- BUS:
  - dmem_req=1 and bus outputs are held stable.
  - StallM = !dmem_ack, i.e. the stall drops in the ack cycle so EX/MEM advances at the same edge.
  - On dmem_ack:
    - W register loads the M inputs; ReadDataW = extended load (0 for stores).
    - dmem_req drops at the edge; go to IDLE; counter cleared.
    - Minimum memory-op latency is 2 cycles; there are no back-to-back bus cycles, since every op spends one cycle in IDLE.
  - Without ack: counter increments each cycle.
  - When the counter equals WAIT_LIMIT-1 without ack: abort (StallM=0 that cycle), dmem_req drops, W loads the M inputs with RegWriteW=0 and BusErrW=1; go to IDLE.
- dmem_ack outside BUS is ignored.
- Stores:
  - sb: be=4'b0001<<a[1:0], wdata={4{d[7:0]}}.
  - sh: be=a[1]?1100:0011, wdata={2{d[15:0]}}.
  - sw: be=1111, wdata=d.
  - Funct3 values 011/11x: treated as w.
- Loads:
  - Select the byte at a[1:0] or the halfword at a[1]; sign-extend for b/h, zero-extend for bu/hu; w passes through.
  - dmem_be=1111 for all loads.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - A memory op with (h/hu and a[0]=1) or (w and a[1:0]!=0) issues no bus request and does not stall.
  - W loads the M inputs next edge with RegWriteW=0 and ReadDataW=0.
  - Extra output MisalignW (1 bit, reset 0) pulses 1 for that W cycle.
- Undefined:
  - No MisalignW port.
  - Offending low address bits are ignored: h uses a[1] only, w ignores a[1:0]; the access proceeds normally.

Test Plan:
- ALU op RegWriteM=1, RdM=5, ALUResultM=0x1234 -> next cycle RdW=5, ALUResultW=0x1234, StallM never 1.
- lb addr 0x103, ack on 1st BUS cycle, rdata=0x80FF_0000 -> StallM 1 for 1 cycle, dmem_addr=0x100, ReadDataW=0xFFFF_FF80; lbu same -> 0x0000_0080.
- sh addr 0x202, WriteDataM=0xDEAD_BEEF, ack after 3 cycles -> dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1, StallM high 4 cycles, RegWriteW=0.
- lw with no ack, WAIT_LIMIT=4 -> dmem_req high 4 cycles then 0, BusErrW=1 for one cycle, RegWriteW=0.
- Assert reset_n=0 mid-BUS -> dmem_req=0 immediately, subsequent ack ignored, state IDLE, W outputs 0.
- lw addr 0x101 with MISALIGN_TRAP_EN -> no dmem_req, MisalignW=1 one cycle; without it -> dmem_addr=0x100, normal word load.
